// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_pkg;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instr, pc} entries with flush.
// A push into a full queue is accepted when a pop happens in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fq_entry_t                push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fq_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fq_entry_t       store [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_pop;
    logic            do_push;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    // Entry storage; contents are only observed while count is non-zero.
    always_ff @(posedge clock) begin
        if (do_push && !flush)
            store[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally at DEPTH; count separates full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC generation, fetch FSM and redirect handling feeding a small fetch queue.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [31:0]     pc;
    logic [31:0]     pc_next;
    logic            enq;
    logic            flush;
    logic            take_redirect;
    logic            deq;
    logic            space;
    logic            is_ebreak;
    fq_entry_t       fq_head;
    fq_entry_t       last_head;
    logic            fq_full;
    logic            fq_empty;
    logic [CW-1:0]   fq_count;

    assign take_redirect = redirect_valid && (state != BOOT);
    assign deq           = out_valid && out_ready;
    assign space         = !fq_full || deq;
    assign is_ebreak     = (imem_instr == EBREAK_INSTR);

    // State register; BOOT covers the cycle where memory data is not yet valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= BOOT;
        else        state <= state_next;
    end

    // Next-state: redirect wins, EBREAK parks the FSM once it is enqueued.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   if (take_redirect)        state_next = FETCH;
                     else if (enq && is_ebreak) state_next = HALTED;
            HALTED:  if (take_redirect)        state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    // Datapath controls: enqueue, flush and the next PC.
    always_comb begin
        enq     = 1'b0;
        flush   = 1'b0;
        pc_next = pc;
        if (take_redirect) begin
            flush   = 1'b1;
            pc_next = redirect_pc & 32'hFFFF_FFFC;
        end else if (state == FETCH && space) begin
            enq = 1'b1;
            if (!is_ebreak) pc_next = pc + 32'd4;
        end
    end

    // PC register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc <= RESET_PC;
        else        pc <= pc_next;
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (enq),
        .push_data ('{instr: imem_instr, pc: pc}),
        .pop       (deq),
        .flush     (flush),
        .head      (fq_head),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    // Remember the most recent head so outputs hold steady while the queue is empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         last_head <= '0;
        else if (!fq_empty) last_head <= fq_head;
    end

    assign imem_addr = pc;
    assign out_valid = (fq_count != '0);
    assign out_instr = out_valid ? fq_head.instr : last_head.instr;
    assign out_pc    = out_valid ? fq_head.pc    : last_head.pc;
    assign halted    = (state == HALTED);

`ifdef FETCH_PERF_EN
    // Saturating event counters for fetched entries and full-queue stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (enq && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (state == FETCH && !space && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected entries are queued by the stimulus,
// a negedge monitor pops and compares on every decode handshake.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [31:0] mem [64];
    fq_entry_t   exp_q [$];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clock = ~clock;

    // Memory returns zero while reset is held.
    assign imem_instr = reset ? mem[imem_addr[7:2]] : 32'h0;

    fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Monitor: every accepted head must match the next expected entry.
    always @(negedge clock) begin
        fq_entry_t e;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got pc %h instr %h want no output", out_pc, out_instr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = start + 32'(4 * i);
            exp_q.push_back('{instr: mem[a[7:2]], pc: a});
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_pc    = target;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        for (int i = 0; i < 200 && !halted; i++) @(negedge clock);
        chk(name, 32'(halted), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Unique addi words so order and duplicates are visible; EBREAKs end runs.
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        mem[7]  = EBREAK_INSTR;
        mem[10] = EBREAK_INSTR;
        mem[18] = EBREAK_INSTR;

        // Reset state and free flow.
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        expect_run(32'h0, 8);
        reset = 1'b1;
        #1;
        chk("boot_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        chk("c1_valid", 32'(out_valid), 32'd0);
        chk("c1_addr", imem_addr, 32'h0);
        @(negedge clock);
        chk("c2_valid", 32'(out_valid), 32'd1);
        chk("c2_pc", out_pc, 32'h0);
        chk("c2_instr", out_instr, mem[0]);
        for (int k = 1; k < 4; k++) begin
            @(negedge clock);
            chk("flow_valid", 32'(out_valid), 32'd1);
            chk("flow_pc", out_pc, 32'(4 * k));
        end
        wait_halted("flow_halt");
        chk("flow_halt_addr", imem_addr, 32'h1C);
        wait_drain("flow_drain");
        @(negedge clock);
        chk("flow_idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: queue fills, PC stalls at 16, then drains in order.
        tick();
        out_ready = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        expect_run(32'h0, 8);
        repeat (8) tick();
        @(negedge clock);
        chk("stall_addr", imem_addr, 32'h10);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_pc", out_pc, 32'h0);
        tick();
        out_ready = 1'b1;
        wait_halted("stall_halt");
        wait_drain("stall_drain");

        // Redirect flushes three queued entries and aligns the target.
        tick();
        out_ready = 1'b0;
        redirect(32'h0);
        repeat (3) tick();
        redirect(32'h0000_0043);
        @(negedge clock);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        expect_run(32'h40, 3);
        tick();
        out_ready = 1'b1;
        wait_halted("redir_halt");
        chk("redir_halt_addr", imem_addr, 32'h48);
        wait_drain("redir_drain");

        // EBREAK at 8, then redirect out of HALTED.
        mem[2] = EBREAK_INSTR;
        tick();
        expect_run(32'h0, 3);
        redirect(32'h0);
        wait_halted("ebrk_halt");
        chk("ebrk_addr", imem_addr, 32'h8);
        wait_drain("ebrk_drain");
        tick();
        expect_run(32'h20, 3);
        redirect(32'h20);
        @(negedge clock);
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_addr", imem_addr, 32'h20);
        wait_halted("resume_halt");
        wait_drain("resume_drain");

        // Asynchronous reset with entries queued and the FSM halted.
        tick();
        out_ready = 1'b0;
        redirect(32'h20);
        repeat (4) tick();
        @(negedge clock);
        chk("pre_arst_halted", 32'(halted), 32'd1);
        chk("pre_arst_valid", 32'(out_valid), 32'd1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_pc", out_pc, 32'h0);

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front-end PC generation and fetch stage. Drives the word address into the combinational instruction memory and captures the returned instruction with its PC into a small fetch queue. Presents the queue to decode through a valid/ready handshake. Handles branch/jump redirects from execute and halts on EBREAK.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
FQ_DEPTH, 4, fetch-queue entries; power of two, 2..16.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
redirect_valid  in  1  execute requests a PC change this cycle.
redirect_pc  in  32  target PC; bits [1:0] ignored and forced to 0.
imem_addr  out  32  byte address to instruction memory; equals the PC register.
imem_instr  in  32  instruction read combinationally from imem_addr in the same cycle.
out_valid  out  1  queue head holds a valid instruction.
out_instr  out  32  queue-head instruction.
out_pc  out  32  PC of out_instr.
out_ready  in  1  decode accepts the head this cycle.
halted  out  1  fetch stopped on EBREAK.

Behaviour:
- Reset (reset low, asynchronous): pc=RESET_PC, queue empty, state=BOOT. Outputs: imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0.
- FSM states: BOOT, FETCH, HALTED.
- BOOT: lasts exactly one cycle after reset deasserts. No enqueue, because memory output is forced to 0 during reset. Transitions to FETCH.
- FETCH: enqueue {imem_instr, pc} when space is available, then pc <= pc+4. Space is available when count<FQ_DEPTH, or when count==FQ_DEPTH and a dequeue occurs in the same cycle. With no space, pc holds (stall).
- EBREAK (imem_instr==32'h0010_0073) enqueued in FETCH: the entry is enqueued, pc holds, and state becomes HALTED. halted=1 from the next cycle.
- HALTED: no enqueue, pc holds, and the queue keeps draining to decode. Only a redirect or reset leaves HALTED; a redirect goes to FETCH and clears halted.
- Dequeue occurs when out_valid && out_ready. The head advances the next cycle.
- Latency: an instruction at imem_addr in cycle N is visible at out_valid/out_instr in cycle N+1 at the earliest (registered queue).
- Redirect (any state except BOOT) has top priority:
  - queue flushed (count=0, out_valid=0 next cycle);
  - pc <= {redirect_pc[31:2],2'b00};
  - no enqueue that cycle;
  - a handshake occurring that cycle is still counted as consumed by decode;
  - the first fetch from the new PC occurs the following cycle.
- Redirect in BOOT is ignored.
- Address arithmetic is 32-bit modulo: pc=32'hFFFF_FFFC wraps to 0. Mapping onto the memory word range is the memory's concern.
- out_instr/out_pc hold their last value when out_valid=0. They must not be X after reset.
- Queue pointers are log2(FQ_DEPTH) bits with wrap. A separate count of width log2(FQ_DEPTH)+1 distinguishes full from empty.

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetched[31:0] and perf_stall[31:0].
- perf_fetched increments per enqueue.
- perf_stall increments per FETCH-state cycle with no space.
- Both reset to 0 and saturate at 32'hFFFF_FFFF.
When undefined, the ports and counters do not exist and the rest of the behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - EBREAK_INSTR constant;
  - fetch_state_t enum {BOOT, FETCH, HALTED};
  - fq_entry_t struct {logic [31:0] instr; logic [31:0] pc}.
- One sub-module, fetch_queue: a parameterised synchronous FIFO of fq_entry_t with push/pop/flush/full/empty/count. Same clock and active-low asynchronous reset.
- fetch_unit holds the PC, FSM and redirect logic.

Test Plan:
- Reset held low for 3 cycles, then released, with RESET_PC=0 → imem_addr=0 and out_valid=0 during reset and BOOT. At cycle 2 after release, out_valid=1, out_pc=0, out_instr=mem[0].
- Free flow with out_ready=1 and nops in memory → one instruction per cycle, out_pc sequence 0,4,8,12 with no gaps.
- out_ready=0 from the first fetch → count reaches 4, imem_addr holds at 16 and out_pc stays 0. Raising out_ready drains 0,4,8,12,16 in order with no lost or duplicate entries.
- Redirect to 32'h0000_0043 while 3 entries are queued → out_valid=0 next cycle and imem_addr=32'h40. The next delivered out_pc is 32'h40.
- EBREAK at address 8 → entries 0,4,8 are delivered, halted=1 and imem_addr holds at 8. A redirect to 0x20 clears halted and fetch resumes at 0x20.
- Async reset asserted mid-stream with the queue partially full → out_valid=0, imem_addr=RESET_PC and halted=0 immediately, without waiting for a clock edge.
